// File: rtl/handle_button_pkg.sv
// Shared constants, repeat-FSM state encoding and the wrap-around step helper
// used by the front-panel button handler.
package handle_button_pkg;

  localparam int unsigned TICK_DIV_DEF  = 20000;
  localparam int unsigned DEB_TICKS_DEF = 10;
  localparam int unsigned REP_DLY_DEF   = 500;
  localparam int unsigned REP_PER_DEF   = 100;
  localparam logic [6:0]  MAIN_MAX_DEF  = 7'd15;
  localparam logic [6:0]  SUB_MAX_DEF   = 7'd99;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } repState_e;

  typedef struct packed {
    logic level;
    logic press;
  } btnState_t;

  // Mode values wrap at both ends so the user can scroll in either direction.
  function automatic logic [6:0] stepValue(input logic [6:0] value,
                                           input logic [6:0] maxValue,
                                           input logic       up);
    if (up) begin
      return (value == maxValue) ? 7'd0 : value + 7'd1;
    end
    return (value == 7'd0) ? maxValue : value - 7'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-FF synchroniser, tick-sampled debounce and a press pulse
// that coincides with the first cycle of the accepted pressed level.
module btn_debounce
  import handle_button_pkg::*;
#(
  parameter int unsigned DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      btn_i,
  input  logic      tick_i,
  output btnState_t state_o
);

  localparam int CW = $clog2(DEB_TICKS + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // Any tick that sees the synced level agree with the accepted level restarts the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (tick_i) begin
        if (sync2_q != level_q) begin
          if (cnt_q == CW'(DEB_TICKS - 1)) begin
            level_q <= sync2_q;
            press_q <= sync2_q;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

  assign state_o = '{level: level_q, press: press_q};

endmodule

// File: rtl/cnt_down.sv
// Free-running reload down-counter; zero_o marks one cycle in every LOAD.
module cnt_down #(
  parameter int unsigned LOAD = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic zero_o
);

  localparam int W = (LOAD > 1) ? $clog2(LOAD) : 1;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_q == '0) begin
      cnt_q <= W'(LOAD - 1);
    end else begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/handle_button.sv
// Front-panel button handler: debounced SEL/UP/DN drive the MAIN/SUB mode
// registers with auto-repeat, wrap-around and a one-cycle mode-change pulse.
module handle_button
  import handle_button_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned DEB_TICKS = DEB_TICKS_DEF,
  parameter int unsigned REP_DLY   = REP_DLY_DEF,
  parameter int unsigned REP_PER   = REP_PER_DEF,
  parameter logic [6:0]  MAIN_MAX  = MAIN_MAX_DEF,
  parameter logic [6:0]  SUB_MAX   = SUB_MAX_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_SEL,
  input  logic       BTN_UP,
  input  logic       BTN_DN,
  output logic [6:0] MAIN_MODE,
  output logic [6:0] SUB_MODE,
  output logic       EDIT_SEL,
  output logic       MODE_CHG
);

  localparam int unsigned REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int RW = $clog2(REP_MAX + 1);

  logic          tick;
  btnState_t     selBtn;
  btnState_t     upBtn;
  btnState_t     dnBtn;
  logic          bothHeld;
  logic          heldLevel;
  logic          stepEn;
  logic          stepUp;

  repState_e     state_q,  state_d;
  logic [RW-1:0] repCnt_q, repCnt_d;
  logic          dirUp_q,  dirUp_d;
  logic [6:0]    main_q,   main_d;
  logic [6:0]    sub_q,    sub_d;
  logic [6:0]    mainPrev_q;
  logic [6:0]    subPrev_q;
  logic          editSel_q;
  logic          modeChg_q;

  cnt_down #(.LOAD(TICK_DIV)) uTick (
    .clk_i  (CLK),
    .rst_i  (RST),
    .zero_o (tick)
  );

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) uSel (
    .clk_i (CLK), .rst_i (RST), .btn_i (BTN_SEL), .tick_i (tick), .state_o (selBtn)
  );

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) uUp (
    .clk_i (CLK), .rst_i (RST), .btn_i (BTN_UP), .tick_i (tick), .state_o (upBtn)
  );

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) uDn (
    .clk_i (CLK), .rst_i (RST), .btn_i (BTN_DN), .tick_i (tick), .state_o (dnBtn)
  );

  assign bothHeld  = upBtn.level & dnBtn.level;
  assign heldLevel = dirUp_q ? upBtn.level : dnBtn.level;

  // Holding both UP and DN parks the FSM; stepping resumes only on a fresh press.
  always_comb begin
    state_d  = state_q;
    repCnt_d = repCnt_q;
    dirUp_d  = dirUp_q;
    stepEn   = 1'b0;
    stepUp   = dirUp_q;
    if (bothHeld) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (upBtn.press || dnBtn.press) begin
            stepEn   = 1'b1;
            stepUp   = upBtn.press;
            dirUp_d  = upBtn.press;
            repCnt_d = RW'(REP_DLY);
            state_d  = HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!heldLevel) begin
            state_d = IDLE;
          end else if (repCnt_q == '0) begin
            stepEn   = 1'b1;
            repCnt_d = RW'(REP_PER);
            state_d  = REPEAT;
          end else if (tick) begin
            repCnt_d = repCnt_q - RW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    main_d = main_q;
    sub_d  = sub_q;
    if (stepEn) begin
      if (editSel_q) begin
        sub_d = stepValue(sub_q, SUB_MAX, stepUp);
      end else begin
        main_d = stepValue(main_q, MAIN_MAX, stepUp);
      end
    end
  end

  // MODE_CHG compares against last cycle's modes, so it fires only on a real change.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      repCnt_q   <= '0;
      dirUp_q    <= 1'b0;
      main_q     <= '0;
      sub_q      <= '0;
      mainPrev_q <= '0;
      subPrev_q  <= '0;
      editSel_q  <= 1'b0;
      modeChg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      repCnt_q   <= repCnt_d;
      dirUp_q    <= dirUp_d;
      main_q     <= main_d;
      sub_q      <= sub_d;
      mainPrev_q <= main_q;
      subPrev_q  <= sub_q;
      modeChg_q  <= (main_q != mainPrev_q) || (sub_q != subPrev_q);
      if (selBtn.press && selBtn.level) begin
        editSel_q <= ~editSel_q;
      end
    end
  end

  assign MAIN_MODE = main_q;
  assign SUB_MODE  = sub_q;
  assign EDIT_SEL  = editSel_q;
  assign MODE_CHG  = modeChg_q;

endmodule

// File: tb/tb_handle_button.sv
// Directed bench for handle_button with a small tick divider so debounce,
// auto-repeat, wrap-around and reset behaviour fit in a short run.
module tb_handle_button;

  logic       CLK     = 1'b0;
  logic       RST     = 1'b1;
  logic       BTN_SEL = 1'b0;
  logic       BTN_UP  = 1'b0;
  logic       BTN_DN  = 1'b0;
  logic [6:0] MAIN_MODE;
  logic [6:0] SUB_MODE;
  logic       EDIT_SEL;
  logic       MODE_CHG;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNo     = 0;
  int chgCount    = 0;
  int chgCycle[64];
  int chgMain[64];

  always #5 CLK = ~CLK;

  handle_button #(
    .TICK_DIV  (4),
    .DEB_TICKS (3),
    .REP_DLY   (10),
    .REP_PER   (4),
    .MAIN_MAX  (7'd3),
    .SUB_MAX   (7'd5)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BTN_SEL   (BTN_SEL),
    .BTN_UP    (BTN_UP),
    .BTN_DN    (BTN_DN),
    .MAIN_MODE (MAIN_MODE),
    .SUB_MODE  (SUB_MODE),
    .EDIT_SEL  (EDIT_SEL),
    .MODE_CHG  (MODE_CHG)
  );

  // Every sampled MODE_CHG cycle counts once, so a stretched pulse shows up as extra pulses.
  always @(negedge CLK) begin
    cycleNo = cycleNo + 1;
    if (MODE_CHG === 1'b1) begin
      if (chgCount < 64) begin
        chgCycle[chgCount] = cycleNo;
        chgMain[chgCount]  = int'(MAIN_MODE);
      end
      chgCount = chgCount + 1;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish within 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic up, input logic dn);
    BTN_SEL = sel;
    BTN_UP  = up;
    BTN_DN  = dn;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int base;
    int found;
    int repExp[6] = '{2, 3, 0, 1, 2, 3};

    waitCycles(5);
    checkOutput("resetMain", MAIN_MODE, 0);
    checkOutput("resetSub",  SUB_MODE,  0);
    checkOutput("resetEdit", EDIT_SEL,  0);
    checkOutput("resetChg",  MODE_CHG,  0);
    RST = 1'b0;
    waitCycles(10);

    // Bouncing UP: 8-cycle halves never span three ticks, then a clean 16-cycle press.
    base = chgCount;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, (i % 2) == 0, 1'b0);
      waitCycles(8);
    end
    checkOutput("bounceNoStep", chgCount - base, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(16);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(40);
    checkOutput("bounceMain",  MAIN_MODE, 1);
    checkOutput("bouncePulse", chgCount - base, 1);

    // 28-tick hold: press step, then 10 ticks (40 cycles) and every 4 ticks (16 cycles).
    base = chgCount;
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(112);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(40);
    checkOutput("repeatCount", chgCount - base, 6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("repeatValue%0d", i), chgMain[base + i], repExp[i]);
    end
    for (int i = 1; i < 6; i++) begin
      checkOutput($sformatf("repeatGap%0d", i), chgCycle[base + i] - chgCycle[base + i - 1],
                  (i == 1) ? 40 : 16);
    end
    checkOutput("repeatMainEnd", MAIN_MODE, 3);

    base = chgCount;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(30);
    checkOutput("selEdit",    EDIT_SEL, 1);
    checkOutput("selNoPulse", chgCount - base, 0);

    base = chgCount;
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(30);
    checkOutput("downWrapSub",  SUB_MODE,  5);
    checkOutput("downWrapMain", MAIN_MODE, 3);
    checkOutput("downPulse",    chgCount - base, 1);

    // UP wraps SUB 5->0, then DN joins before the first repeat and must freeze stepping.
    base = chgCount;
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(20);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(40);
    checkOutput("bothIdle",  int'(dut.state_q), 0);
    checkOutput("bothPulse", chgCount - base, 1);
    waitCycles(20);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(80);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(40);
    checkOutput("bothSub",      SUB_MODE, 0);
    checkOutput("bothNoRepeat", chgCount - base, 1);

    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(30);
    checkOutput("selBackEdit", EDIT_SEL, 0);

    // SEL and UP debounce together: the step lands in MAIN, EDIT_SEL flips alongside it.
    base  = chgCount;
    found = 0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40 && found == 0; i++) begin
      waitCycles(1);
      if (EDIT_SEL === 1'b1) begin
        found = 1;
        checkOutput("selUpMain",   MAIN_MODE, 0);
        checkOutput("selUpSub",    SUB_MODE,  0);
        checkOutput("selUpChgLag", MODE_CHG,  0);
        waitCycles(1);
        checkOutput("selUpChg",    MODE_CHG,  1);
      end
    end
    checkOutput("selUpSeen", found, 1);
    waitCycles(6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(40);
    checkOutput("selUpPulse", chgCount - base, 1);
    checkOutput("selUpEdit",  EDIT_SEL, 1);

    // Reset in the middle of an auto-repeat hold, with UP kept pressed through it.
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(70);
    RST = 1'b1;
    #1;
    checkOutput("midRstMain", MAIN_MODE, 0);
    checkOutput("midRstSub",  SUB_MODE,  0);
    checkOutput("midRstEdit", EDIT_SEL,  0);
    checkOutput("midRstChg",  MODE_CHG,  0);
    waitCycles(3);
    RST  = 1'b0;
    base = chgCount;
    waitCycles(8);
    checkOutput("postRstEarlyMain",  MAIN_MODE, 0);
    checkOutput("postRstEarlyPulse", chgCount - base, 0);
    waitCycles(16);
    checkOutput("postRstMain", MAIN_MODE, 1);
    checkOutput("postRstSub",  SUB_MODE,  0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(40);
    checkOutput("postRstPulse", chgCount - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
